// File: rtl/multi_port_interface_adapter.sv
// Parallel I/O adapter: NUM_PORTS 8-bit DDR ports, TIMER_WIDTH interval timer, maskable IRQ; reads combinational, writes on clk.
// Port input sampling latency 1 clk, or 2 clk with INTERFACE_ADAPTER_INPUT_SYNC_EN defined; no backpressure (CPU bus slave).
module multi_port_interface_adapter #(
  parameter int NUM_PORTS   = 2,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chip_en1,
  input  logic                   chip_en2b,
  input  logic                   readb_write,
  input  logic [3:0]             register_select,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [8*NUM_PORTS-1:0] port_ddr,
  output logic                   irqb
);

  localparam int PW = 8 * NUM_PORTS;
  localparam int HW = TIMER_WIDTH - 8;

  logic                   w_sel, w_wr, w_rd, w_start, w_expire;
  logic [PW-1:0]          r_or, r_ddr, r_smp, w_smp_next;
  logic [NUM_PORTS-1:0]   w_chg, w_port_acc;
  logic [TIMER_WIDTH-1:0] r_latch, r_cnt;
  logic                   r_armed;
  logic [7:0]             r_acr, w_rdat;
  logic [6:0]             r_ifr, r_ier, w_ifr_next;

  assign w_sel    = chip_en1 & ~chip_en2b;
  assign w_wr     = w_sel & ~readb_write;
  assign w_rd     = w_sel & readb_write;
  assign w_start  = w_wr && (register_select == 4'h9);
  assign w_expire = r_armed && (r_cnt == '0);

`ifdef INTERFACE_ADAPTER_INPUT_SYNC_EN
  logic [PW-1:0] r_sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= port_in;
  end
  assign w_smp_next = r_sync;
`else
  assign w_smp_next = port_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_or  <= '0;
      r_ddr <= '0;
      r_smp <= '0;
    end else begin
      r_smp <= w_smp_next;
      if (w_wr) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (register_select == 4'(p))     r_or[8*p +: 8]  <= data_in;
          if (register_select == 4'(p + 4)) r_ddr[8*p +: 8] <= data_in;
        end
      end
    end
  end

  // Change is judged on the incoming sample so the flag appears together with the new read value.
  always_comb begin
    w_chg      = '0;
    w_port_acc = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_chg[p]      = |((w_smp_next[8*p +: 8] ^ r_smp[8*p +: 8]) & ~r_ddr[8*p +: 8]);
      w_port_acc[p] = w_sel && (register_select == 4'(p));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_latch <= '1;
      r_cnt   <= '1;
      r_armed <= 1'b0;
      r_acr   <= '0;
    end else begin
      if (w_wr) begin
        case (register_select)
          4'h8, 4'hA: r_latch[7:0]             <= data_in;
          4'h9, 4'hB: r_latch[TIMER_WIDTH-1:8] <= data_in[HW-1:0];
          4'hC:       r_acr                    <= data_in;
          default: ;
        endcase
      end
      if (w_start) begin
        r_cnt   <= {data_in[HW-1:0], r_latch[7:0]};
        r_armed <= 1'b1;
      end else if (w_expire && r_acr[0]) begin
        r_cnt <= r_latch;
      end else begin
        r_cnt <= r_cnt - 1'b1;
        if (w_expire) r_armed <= 1'b0;
      end
    end
  end

  // Clears first, then set events override; a timer start overrides its own expiry.
  always_comb begin
    w_ifr_next = r_ifr;
    if (w_wr && register_select == 4'hD) w_ifr_next = w_ifr_next & ~data_in[6:0];
    if (w_rd && register_select == 4'h8) w_ifr_next[0] = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_port_acc[p]) w_ifr_next[1+p] = 1'b0;
      if (w_chg[p])      w_ifr_next[1+p] = 1'b1;
    end
    if (w_start)       w_ifr_next[0] = 1'b0;
    else if (w_expire) w_ifr_next[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ifr <= '0;
      r_ier <= '0;
    end else begin
      r_ifr <= w_ifr_next;
      if (w_wr && register_select == 4'hE) begin
        if (data_in[7]) r_ier <= r_ier | data_in[6:0];
        else            r_ier <= r_ier & ~data_in[6:0];
      end
    end
  end

  assign irqb = ~|(r_ifr & r_ier);

  always_comb begin
    w_rdat = 8'h00;
    if (w_rd) begin
      case (register_select)
        4'h8:       w_rdat = r_cnt[7:0];
        4'h9:       w_rdat = 8'(r_cnt >> 8);
        4'hA:       w_rdat = r_latch[7:0];
        4'hB:       w_rdat = 8'(r_latch >> 8);
        4'hC:       w_rdat = r_acr;
        4'hD:       w_rdat = {~irqb, r_ifr};
        4'hE:       w_rdat = {1'b1, r_ier};
        default: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (register_select == 4'(p))
              w_rdat = (r_or[8*p +: 8] & r_ddr[8*p +: 8]) | (r_smp[8*p +: 8] & ~r_ddr[8*p +: 8]);
            if (register_select == 4'(p + 4))
              w_rdat = r_ddr[8*p +: 8];
          end
        end
      endcase
    end
  end

  assign data_out = w_rdat;
  assign port_out = r_or;
  assign port_ddr = r_ddr;

endmodule
